// File: rtl/pulse_integrator_16.sv
// Gated pulse integrator: on a trigger edge, waits start_dly samples, then sums
// win_len signed samples from the anti-droop stage and holds the result until
// the consumer acknowledges it.
module pulse_integrator_16 #(
  parameter int unsigned SUM_W = 24  // must be >= 24 so 255 full-scale samples fit
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trig,
  input  logic signed [15:0]      din,
  input  logic                    din_oflow,
  input  logic        [7:0]       start_dly,
  input  logic        [7:0]       win_len,
  input  logic                    sum_ack,
  output logic signed [SUM_W-1:0] sum,
  output logic                    sum_valid,
  output logic                    sum_oflow,
  output logic                    busy,
  output logic                    missed_trig
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StInteg = 2'd2,
    StHold  = 2'd3
  } state_e;

  state_e r_state;

  // Trigger synchroniser; kept as discrete flops so the pair stays a real synchroniser.
  (* shreg_extract = "no", async_reg = "true" *) logic r_trig_a;
  (* shreg_extract = "no", async_reg = "true" *) logic r_trig_b;

  logic        [7:0]       r_cnt;
  logic        [7:0]       r_win;
  logic signed [SUM_W-1:0] r_acc;
  logic signed [SUM_W-1:0] r_sum;
  logic                    r_win_oflow;
  logic                    r_sum_oflow;
  logic                    r_sum_valid;
  logic                    r_busy;
  logic                    r_missed;

  logic                    w_edge;
  logic                    w_acc_en;
  logic signed [SUM_W-1:0] w_din_ext;
  logic signed [SUM_W-1:0] w_acc_add;
  logic signed [SUM_W-1:0] w_acc_fin;
  logic                    w_of_fin;

  assign w_edge    = r_trig_a & ~r_trig_b;
  assign w_din_ext = {{(SUM_W-16){din[15]}}, din};
  // In INTEG a zero count means an empty window: nothing is accumulated.
  assign w_acc_en  = (r_cnt != 8'd0);
  assign w_acc_add = r_acc + w_din_ext;
  assign w_acc_fin = w_acc_en ? w_acc_add : r_acc;
  assign w_of_fin  = r_win_oflow | (w_acc_en & din_oflow);

  assign sum         = r_sum;
  assign sum_valid   = r_sum_valid;
  assign sum_oflow   = r_sum_oflow;
  assign busy        = r_busy;
  assign missed_trig = r_missed;

  // Two-flop synchroniser for the asynchronous trigger level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_a <= 1'b0;
      r_trig_b <= 1'b0;
    end else begin
      r_trig_a <= trig;
      r_trig_b <= r_trig_a;
    end
  end

  // Window sequencer with registered result and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 8'd0;
      r_win       <= 8'd0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_win_oflow <= 1'b0;
      r_sum_oflow <= 1'b0;
      r_sum_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_missed    <= 1'b0;
    end else begin
      if (w_edge && (r_state != StIdle)) begin
        r_missed <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (w_edge) begin
            r_win       <= win_len;
            r_acc       <= '0;
            r_win_oflow <= 1'b0;
            r_busy      <= 1'b1;
            if (start_dly != 8'd0) begin
              r_state <= StDelay;
              r_cnt   <= start_dly;
            end else begin
              r_state <= StInteg;
              r_cnt   <= win_len;
            end
          end
        end
        StDelay: begin
          if (r_cnt == 8'd1) begin
            r_state <= StInteg;
            r_cnt   <= r_win;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StInteg: begin
          if (w_acc_en) begin
            r_acc       <= w_acc_add;
            r_win_oflow <= w_of_fin;
            r_cnt       <= r_cnt - 8'd1;
          end
          // Last sample (or empty window): publish the result in the same cycle.
          if (r_cnt <= 8'd1) begin
            r_state     <= StHold;
            r_sum       <= w_acc_fin;
            r_sum_oflow <= w_of_fin;
            r_sum_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        StHold: begin
          if (sum_ack) begin
            r_sum_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_integrator_16.sv
module tb_pulse_integrator_16;

  localparam int SW = 24;

  logic                 clk;
  logic                 rst_n;
  logic                 trig;
  logic signed [15:0]   din;
  logic                 din_oflow;
  logic        [7:0]    start_dly;
  logic        [7:0]    win_len;
  logic                 sum_ack;
  logic signed [SW-1:0] sum;
  logic                 sum_valid;
  logic                 sum_oflow;
  logic                 busy;
  logic                 missed_trig;

  typedef struct packed {
    logic signed [SW-1:0] s;
    logic                 o;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic signed [SW-1:0] last_sum;
  logic                 last_of;

  pulse_integrator_16 #(.SUM_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig       (trig),
    .din        (din),
    .din_oflow  (din_oflow),
    .start_dly  (start_dly),
    .win_len    (win_len),
    .sum_ack    (sum_ack),
    .sum        (sum),
    .sum_valid  (sum_valid),
    .sum_oflow  (sum_oflow),
    .busy       (busy),
    .missed_trig(missed_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One trigger-to-result window. Edge numbering: edge 0 is the first clock edge
  // that samples trig high; samples at edges 2+sd .. 1+sd+wl are integrated.
  task automatic run_window(input string tag, input int sd, input int wl, input int base,
                            input int step, input int oflow_edge, input int retrig_edge,
                            input bit ack_first);
    exp_t         ex;
    longint       acc;
    int           e;
    int           lat;
    int           v;
    acc  = 0;
    ex.o = 1'b0;
    for (int k = 2 + sd; k <= 1 + sd + wl; k++) begin
      acc += longint'(base + step * k);
      if (k == oflow_edge) ex.o = 1'b1;
    end
    ex.s = SW'(acc);
    sb.push_back(ex);
    lat = 2 + sd + ((wl == 0) ? 1 : wl);

    start_dly = 8'(sd);
    win_len   = 8'(wl);
    trig      = 1'b1;
    sum_ack   = ack_first;
    v         = base;
    din       = 16'(v);
    din_oflow = (oflow_edge == 0);
    e = 0;
    while (e < lat + 20) begin
      tick();
      e++;
      v         = base + step * e;
      din       = 16'(v);
      din_oflow = (e == oflow_edge);
      sum_ack   = 1'b0;
      if (e == 2) begin
        // captured values must be immune to later changes
        start_dly = ~8'(sd);
        win_len   = ~8'(wl);
      end
      if (e == 3) trig = 1'b0;
      if (retrig_edge > 3 && e == retrig_edge) trig = 1'b1;
      if (retrig_edge > 3 && e == retrig_edge + 2) trig = 1'b0;
      if (sum_valid === 1'b1) break;
    end
    din_oflow = 1'b0;
    check({tag, "_latency"}, e, lat);
    ex = sb.pop_front();
    check({tag, "_sum"}, sum, ex.s);
    check({tag, "_oflow"}, sum_oflow, ex.o);
    check({tag, "_busy_in_hold"}, busy, 1'b0);
    last_sum = ex.s;
    last_of  = ex.o;
  endtask

  task automatic do_ack(input string tag);
    sum_ack = 1'b1;
    tick();
    sum_ack = 1'b0;
    check({tag, "_valid_after_ack"}, sum_valid, 1'b0);
    check({tag, "_sum_retained"}, sum, last_sum);
  endtask

  initial begin
    bit all_high;
    rst_n     = 1'b0;
    trig      = 1'b0;
    din       = '0;
    din_oflow = 1'b0;
    start_dly = '0;
    win_len   = '0;
    sum_ack   = 1'b0;
    #23;
    check("rst_sum", sum, 0);
    check("rst_valid", sum_valid, 1'b0);
    check("rst_oflow", sum_oflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_missed", missed_trig, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Basic window: 4 x 100 after 2-sample delay
    run_window("basic", 2, 4, 100, 0, -1, -1, 1'b0);
    do_ack("basic");
    // ack outside HOLD is ignored
    sum_ack = 1'b1;
    tick(); tick(); tick();
    sum_ack = 1'b0;
    check("idle_ack_sum", sum, 400);
    check("idle_ack_busy", busy, 1'b0);
    tick();

    // Full-scale negative, longest window, no delay
    run_window("fullneg", 0, 255, -32768, 0, -1, -1, 1'b0);
    check("fullneg_value", sum, -8355840);
    do_ack("fullneg");
    tick();

    // Varying samples expose window alignment; overflow on the middle sample
    run_window("of_mid", 1, 3, -50, 20, 4, -1, 1'b0);
    // ack coincides with the next trigger: edge must be taken right after HOLD exits
    run_window("of_delay_only", 1, 3, 9, 1, 2, -1, 1'b1);
    run_window("of_last", 1, 3, 9, 1, 5, -1, 1'b1);
    check("no_missed_yet", missed_trig, 1'b0);
    do_ack("of_last");
    tick();

    // Retrigger during INTEG, then during HOLD
    run_window("retrig", 1, 10, 7, 3, -1, 6, 1'b0);
    check("retrig_integ_missed", missed_trig, 1'b1);
    trig = 1'b1;
    tick(); tick(); tick();
    trig = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("retrig_hold_valid", sum_valid, 1'b1);
    check("retrig_hold_sum", sum, last_sum);
    check("retrig_hold_busy", busy, 1'b0);
    do_ack("retrig");
    for (int k = 0; k < 8; k++) tick();
    check("retrig_no_second_valid", sum_valid, 1'b0);
    check("retrig_no_second_busy", busy, 1'b0);
    check("retrig_missed_sticky", missed_trig, 1'b1);

    // Empty window held without ack
    run_window("empty", 3, 0, 1234, 5, 6, -1, 1'b0);
    all_high = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (sum_valid !== 1'b1) all_high = 1'b0;
    end
    check("empty_valid_held50", all_high, 1'b1);
    do_ack("empty");
    tick();

    // Reset in the middle of an integration window
    start_dly = 8'd0;
    win_len   = 8'd20;
    din       = 16'sd500;
    trig      = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum", sum, 0);
    check("mid_rst_valid", sum_valid, 1'b0);
    check("mid_rst_oflow", sum_oflow, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_missed", missed_trig, 1'b0);
    trig = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    check("mid_discard_valid", sum_valid, 1'b0);
    check("mid_discard_busy", busy, 1'b0);
    run_window("fresh", 2, 5, -1000, -17, 5, -1, 1'b0);
    do_ack("fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
